// File: rtl/conv_output_stream_sink.sv
// conv_output_stream_sink
// AXI-Stream slave that terminates the convolution engine's 64-bit pixel stream.
// Each accepted beat (4 pixels) becomes one output-BRAM word write, one channel plane
// at a time. A finished plane is held in BRAM until the downstream stage acknowledges
// it via drain_ack_i; only then is the next plane accepted. tlast framing is checked
// but never alters plane length, which is fixed by the image size latched at start.
//
// Optional feature: define CONV_SINK_RELU_EN to clamp negative pixels to zero on the
// write path (no added latency). Without it the beat is written verbatim.

module conv_output_stream_sink #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned PIXEL_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            image_size_choose_i,
    input  logic [1:0]            channel_size_choose_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tlast_i,
    output logic                  s_axis_tready_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_din_o,
    output logic                  chan_done_o,
    input  logic                  drain_ack_i,
    output logic [8:0]            chan_index_o,
    output logic                  frame_done_o,
    output logic                  tlast_err_o
);

    localparam int unsigned Lanes = DATA_WIDTH / PIXEL_WIDTH;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StHold = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Plane length minus one in words: (4 << sel)^2 / 4 = 4 << (2*sel); selects 6,7 clamp to 128.
    function automatic logic [ADDR_WIDTH-1:0] words_m1_of(input logic [2:0] sel);
        logic [2:0]  s;
        logic [31:0] words;
        s     = (sel > 3'd5) ? 3'd5 : sel;
        words = 32'd4 << {s, 1'b0};
        return ADDR_WIDTH'(words - 32'd1);
    endfunction

    // Channel count minus one; select 3 falls back to 64 channels.
    function automatic logic [7:0] chan_last_of(input logic [1:0] sel);
        logic [7:0] last;
        case (sel)
            2'd0:    last = 8'd255;
            2'd1:    last = 8'd127;
            default: last = 8'd63;
        endcase
        return last;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] words_m1_q, words_m1_d;
    logic [7:0]            chan_last_q, chan_last_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [8:0]            chan_index_q, chan_index_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  chan_done_q, chan_done_d;
    logic                  tlast_err_q, tlast_err_d;

    logic                  accept;
    logic                  last_word;
    logic                  more_chans;
    logic [DATA_WIDTH-1:0] beat_data;

    // Ready depends only on registered state, never on tvalid.
    assign accept     = s_axis_tvalid_i && (state_q == StRecv);
    assign last_word  = (word_cnt_q == words_m1_q);
    assign more_chans = (chan_index_q < {1'b0, chan_last_q});

    // Write-data shaping: optional per-lane clamp of negative pixels.
    always_comb begin
        beat_data = s_axis_tdata_i;
`ifdef CONV_SINK_RELU_EN
        for (int i = 0; i < int'(Lanes); i++) begin
            if (s_axis_tdata_i[i*PIXEL_WIDTH + PIXEL_WIDTH - 1]) begin
                beat_data[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
            end
        end
`endif
    end

    // Next-state: plane sequencing, beat-to-write unpacking and tlast framing check.
    always_comb begin
        state_d      = state_q;
        words_m1_d   = words_m1_q;
        chan_last_d  = chan_last_q;
        word_cnt_d   = word_cnt_q;
        chan_index_d = chan_index_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        din_d        = din_q;
        chan_done_d  = chan_done_q;
        tlast_err_d  = tlast_err_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StRecv;
                    words_m1_d   = words_m1_of(image_size_choose_i);
                    chan_last_d  = chan_last_of(channel_size_choose_i);
                    word_cnt_d   = '0;
                    chan_index_d = '0;
                    tlast_err_d  = 1'b0;
                end
            end
            StRecv: begin
                if (accept) begin
                    we_d       = 1'b1;
                    addr_d     = word_cnt_q;
                    din_d      = beat_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    // Framing error is only flagged; the plane length stays word-count driven.
                    if (s_axis_tlast_i != last_word) begin
                        tlast_err_d = 1'b1;
                    end
                    if (last_word) begin
                        state_d     = StHold;
                        chan_done_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (drain_ack_i) begin
                    chan_done_d = 1'b0;
                    if (more_chans) begin
                        state_d      = StRecv;
                        chan_index_d = chan_index_q + 1'b1;
                        word_cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress and suppresses pending writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            words_m1_q   <= words_m1_of(3'd5);
            chan_last_q  <= chan_last_of(2'd0);
            word_cnt_q   <= '0;
            chan_index_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            chan_done_q  <= 1'b0;
            tlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_m1_q   <= words_m1_d;
            chan_last_q  <= chan_last_d;
            word_cnt_q   <= word_cnt_d;
            chan_index_q <= chan_index_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            chan_done_q  <= chan_done_d;
            tlast_err_q  <= tlast_err_d;
        end
    end

    assign s_axis_tready_o = (state_q == StRecv);
    assign bram_we_o       = we_q;
    assign bram_addr_o     = addr_q;
    assign bram_din_o      = din_q;
    assign chan_done_o     = chan_done_q;
    assign chan_index_o    = chan_index_q;
    assign frame_done_o    = (state_q == StDone);
    assign tlast_err_o     = tlast_err_q;

endmodule

// File: tb/tb_conv_output_stream_sink.sv
// Self-checking bench for conv_output_stream_sink: random beats against a queue-based
// model of the expected BRAM writes (address = beat position within its plane).

module tb_conv_output_stream_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  img_sel = 3'd0;
    logic [1:0]  ch_sel = 2'd0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        bram_we;
    logic [13:0] bram_addr;
    logic [63:0] bram_din;
    logic        chan_done;
    logic        drain_ack = 1'b0;
    logic [8:0]  chan_index;
    logic        frame_done;
    logic        tlast_err;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;

    logic [13:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    bit          fixed_en = 1'b0;
    logic [63:0] fixed_data = '0;

    always #5 clk = ~clk;

    conv_output_stream_sink dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .start_i               (start),
        .image_size_choose_i   (img_sel),
        .channel_size_choose_i (ch_sel),
        .s_axis_tdata_i        (tdata),
        .s_axis_tvalid_i       (tvalid),
        .s_axis_tlast_i        (tlast),
        .s_axis_tready_o       (tready),
        .bram_we_o             (bram_we),
        .bram_addr_o           (bram_addr),
        .bram_din_o            (bram_din),
        .chan_done_o           (chan_done),
        .drain_ack_i           (drain_ack),
        .chan_index_o          (chan_index),
        .frame_done_o          (frame_done),
        .tlast_err_o           (tlast_err)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    // Expected written word: negative signed pixels become zero when the clamp is built in.
    function automatic logic [63:0] model_data(input logic [63:0] d);
        logic [63:0]        r;
        logic signed [15:0] px;
        r = d;
`ifdef CONV_SINK_RELU_EN
        for (int i = 0; i < 4; i++) begin
            px = d[16*i +: 16];
            if (px < 0) r[16*i +: 16] = 16'h0000;
        end
`else
        px = '0;
`endif
        return r;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; tvalid = 1'b0; tlast = 1'b0; drain_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic pulse_start(input logic [2:0] isel, input logic [1:0] csel);
        @(posedge clk); #1;
        start = 1'b1; img_sel = isel; ch_sel = csel;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1;
        drain_ack = 1'b1;
        @(posedge clk); #1;
        drain_ack = 1'b0;
    endtask

    // Streams n beats (tvalid with probability prob%) and checks every BRAM write in order.
    task automatic send_plane(input int n, input int tlast_pos, input int prob,
                              input bit expect_done);
        int idx = 0;
        int cyc = 0;
        int budget = n * 20 + 50;
        logic [13:0] ea;
        logic [63:0] ed;
        while ((idx < n || exp_addr_q.size() > 0) && cyc < budget) begin
            @(posedge clk); #1;
            tvalid = (idx < n) && ($urandom_range(99) < prob);
            tdata  = fixed_en ? fixed_data : {$urandom, $urandom};
            tlast  = (idx == tlast_pos);
            @(negedge clk);
            if (bram_we === 1'b1) begin
                tests++;
                if (exp_addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL write_unexpected: addr=%0d din=%h, required no write",
                             bram_addr, bram_din);
                end else begin
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (bram_addr !== ea || bram_din !== ed) begin
                        fails++;
                        $display("FAIL write_data: addr=%0d din=%h, required addr=%0d din=%h",
                                 bram_addr, bram_din, ea, ed);
                    end
                end
            end
            if (tvalid && tready === 1'b1) begin
                exp_addr_q.push_back(14'(idx));
                exp_data_q.push_back(model_data(tdata));
                idx++;
            end
            cyc++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tests++;
        if (cyc >= budget) begin
            fails++;
            $display("FAIL plane_timeout: accepted=%0d pending=%0d, required accepted=%0d pending=0",
                     idx, exp_addr_q.size(), n);
        end
        if (expect_done) begin
            tests++;
            if (chan_done !== 1'b1 || tready !== 1'b0) begin
                fails++;
                $display("FAIL plane_done: chan_done=%b tready=%b, required 1 0", chan_done, tready);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if ({tready, bram_we, bram_addr, bram_din, chan_done, chan_index, frame_done, tlast_err}
            !== '0) begin
            fails++;
            $display("FAIL reset_outputs: tready=%b we=%b addr=%0d din=%h done=%b idx=%0d fd=%b err=%b, required all 0",
                     tready, bram_we, bram_addr, bram_din, chan_done, chan_index, frame_done,
                     tlast_err);
        end
    endtask

    // 4x4 image, 64 channels: full frame, frame_done exactly once at the end.
    task automatic test_small_frame();
        int fd_start;
        do_reset();
        pulse_start(3'd0, 2'd2);
        fd_start = fd_count;
        for (int p = 0; p < 64; p++) begin
            @(negedge clk);
            tests++;
            if (chan_index !== 9'(p) || tready !== 1'b1) begin
                fails++;
                $display("FAIL frame_chan_index: idx=%0d tready=%b, required %0d 1",
                         chan_index, tready, p);
            end
            send_plane(4, 3, 100, 1'b1);
            pulse_ack();
            @(negedge clk);
            tests++;
            if (chan_done !== 1'b0 || frame_done !== (p == 63)) begin
                fails++;
                $display("FAIL frame_after_ack: chan_done=%b frame_done=%b, required 0 %b",
                         chan_done, frame_done, (p == 63));
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (fd_count - fd_start !== 1 || tready !== 1'b0 || tlast_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_count: pulses=%0d tready=%b err=%b, required 1 0 0",
                     fd_count - fd_start, tready, tlast_err);
        end
    endtask

    // 128x128 single plane with 50% tvalid: 4096 in-order writes.
    task automatic test_big_plane();
        do_reset();
        pulse_start(3'd7, 2'd2);
        send_plane(4096, 4095, 50, 1'b1);
        tests++;
        if (tlast_err !== 1'b0 || chan_index !== 9'd0) begin
            fails++;
            $display("FAIL big_plane_state: err=%b idx=%0d, required 0 0", tlast_err, chan_index);
        end
    endtask

    task automatic test_tlast_err();
        do_reset();
        pulse_start(3'd0, 2'd0);
        pulse_ack();
        @(negedge clk);
        tests++;
        if (tlast_err !== 1'b0 || chan_index !== 9'd0 || tready !== 1'b1) begin
            fails++;
            $display("FAIL ack_outside_hold: err=%b idx=%0d tready=%b, required 0 0 1",
                     tlast_err, chan_index, tready);
        end
        send_plane(4, 1, 100, 1'b1);
        tests++;
        if (tlast_err !== 1'b1) begin
            fails++;
            $display("FAIL tlast_early: err=%b, required 1", tlast_err);
        end
        pulse_start(3'd2, 2'd1);
        @(negedge clk);
        tests++;
        if (tlast_err !== 1'b1 || chan_done !== 1'b1 || tready !== 1'b0) begin
            fails++;
            $display("FAIL start_outside_idle: err=%b done=%b tready=%b, required 1 1 0",
                     tlast_err, chan_done, tready);
        end
        pulse_ack();
        send_plane(4, 3, 100, 1'b1);
        tests++;
        if (tlast_err !== 1'b1 || chan_index !== 9'd1) begin
            fails++;
            $display("FAIL tlast_sticky: err=%b idx=%0d, required 1 1", tlast_err, chan_index);
        end
        do_reset();
        pulse_start(3'd0, 2'd2);
        send_plane(4, -1, 100, 1'b1);
        tests++;
        if (tlast_err !== 1'b1) begin
            fails++;
            $display("FAIL tlast_missing: err=%b, required 1", tlast_err);
        end
    endtask

    task automatic test_hold_backpressure();
        do_reset();
        pulse_start(3'd1, 2'd2);
        send_plane(16, 15, 70, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tvalid = 1'b1;
            tdata  = {$urandom, $urandom};
            @(negedge clk);
            tests++;
            if (tready !== 1'b0 || bram_we !== 1'b0 || chan_done !== 1'b1) begin
                fails++;
                $display("FAIL hold_stall: tready=%b we=%b done=%b, required 0 0 1",
                         tready, bram_we, chan_done);
            end
        end
        tvalid = 1'b0;
        pulse_ack();
        @(negedge clk);
        tests++;
        if (tready !== 1'b1 || chan_index !== 9'd1 || chan_done !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: tready=%b idx=%0d done=%b, required 1 1 0",
                     tready, chan_index, chan_done);
        end
        send_plane(16, 15, 100, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start(3'd3, 2'd2);
        send_plane(256, 255, 100, 1'b1);
        pulse_ack();
        send_plane(100, 5, 100, 1'b0);
        tests++;
        if (chan_index !== 9'd1 || tlast_err !== 1'b1 || tready !== 1'b1) begin
            fails++;
            $display("FAIL mid_plane_state: idx=%0d err=%b tready=%b, required 1 1 1",
                     chan_index, tlast_err, tready);
        end
        @(posedge clk); #1;
        rst = 1'b1; tvalid = 1'b1; tdata = {$urandom, $urandom};
        @(negedge clk);
        tests++;
        if (tready !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_ready: tready=%b, required 1", tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (tready !== 1'b0 || bram_we !== 1'b0 || chan_index !== 9'd0 ||
                tlast_err !== 1'b0) begin
                fails++;
                $display("FAIL reset_abort: tready=%b we=%b idx=%0d err=%b, required 0 0 0 0",
                         tready, bram_we, chan_index, tlast_err);
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++;
        if (tready !== 1'b0) begin
            fails++;
            $display("FAIL rst_beats_start: tready=%b, required 0", tready);
        end
    endtask

    task automatic test_relu();
        logic [63:0] req;
`ifdef CONV_SINK_RELU_EN
        req = 64'h0000_7FFF_0000_0001;
`else
        req = 64'h8000_7FFF_FFFF_0001;
`endif
        do_reset();
        pulse_start(3'd0, 2'd2);
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = 64'h8000_7FFF_FFFF_0001; tlast = 1'b0;
        @(posedge clk); #1;
        tvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (bram_we !== 1'b1 || bram_addr !== 14'd0 || bram_din !== req) begin
            fails++;
            $display("FAIL relu_lanes: we=%b addr=%0d din=%h, required 1 0 %h",
                     bram_we, bram_addr, bram_din, req);
        end
        do_reset();
        pulse_start(3'd0, 2'd2);
        fixed_en   = 1'b1;
        fixed_data = 64'hFFFF_0000_8001_7FFE;
        send_plane(4, 3, 100, 1'b1);
        fixed_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_big_plane();
        test_tlast_err();
        test_hold_backpressure();
        test_reset_mid();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
